// File: rtl/sub_datapath.sv
`default_nettype none
// ============================================================================
// Module      : sub_datapath
// Description : Register-file datapath driven by control_unit. It holds
//               sixteen WIDTH-bit registers, a write-source mux and a
//               subtractor ALU (A - B). It returns registered no-borrow and
//               zero flags, and captures a register into 'result' when
//               control_unit releases busy.
// Ports       : clk          - system clock, rising edge
//               rst          - synchronous active-high reset
//               data_in      - external operand (insel = 00)
//               insel        - write source: 00 data_in, 01 cu_const,
//                              10 ALU result, 11 operand A (move)
//               cu_const     - constant from control_unit
//               in_mux_add   - operand A select (R0..R7 only)
//               out_mux_add  - operand B / result-capture select (R0..R15)
//               reg_add      - write destination (R0..R15)
//               we           - register-file write enable
//               busy         - control_unit busy; falling edge captures
//               co, z        - flags of the last ALU write
//               result       - captured register value
//               result_valid - one-cycle pulse when result loads
// Revision    : 1.0 - initial release
// ============================================================================
module sub_datapath #(
    parameter int WIDTH = 8,
    parameter int NREG  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic [1:0]       insel,
    input  logic [WIDTH-1:0] cu_const,
    input  logic [2:0]       in_mux_add,
    input  logic [3:0]       out_mux_add,
    input  logic [3:0]       reg_add,
    input  logic             we,
    input  logic             busy,
    output logic             co,
    output logic             z,
    output logic [WIDTH-1:0] result,
    output logic             result_valid
);

    localparam logic [1:0] SEL_DATA  = 2'b00;
    localparam logic [1:0] SEL_CONST = 2'b01;
    localparam logic [1:0] SEL_ALU   = 2'b10;
    localparam logic [1:0] SEL_MOVE  = 2'b11;

    logic [WIDTH-1:0] regs_q [NREG];
    logic             busy_q;

    logic [WIDTH-1:0] opa_w;
    logic [WIDTH-1:0] opb_w;
    logic [WIDTH:0]   diff_w;
    logic [WIDTH-1:0] alu_res_w;
    logic             alu_co_w;
    logic [WIDTH-1:0] wdata_d;
    logic             capture_w;
    logic             flag_upd_w;

    // Operand A only spans R0..R7 because its select is 3 bits wide.
    assign opa_w = regs_q[{1'b0, in_mux_add}];
    assign opb_w = regs_q[out_mux_add];

    // A + ~B + 1: the carry out is the no-borrow flag (1 iff A >= B).
    assign diff_w    = {1'b0, opa_w} + {1'b0, ~opb_w} + {{WIDTH{1'b0}}, 1'b1};
    assign alu_res_w = diff_w[WIDTH-1:0];
    assign alu_co_w  = diff_w[WIDTH];

    always_comb begin
        wdata_d = data_in;
        case (insel)
            SEL_DATA:  wdata_d = data_in;
            SEL_CONST: wdata_d = cu_const;
            SEL_ALU:   wdata_d = alu_res_w;
            SEL_MOVE:  wdata_d = opa_w;
            default:   wdata_d = data_in;
        endcase
    end

    assign flag_upd_w = we && (insel == SEL_ALU);
    assign capture_w  = busy_q && !busy;

    // Register file: reads are combinational from the stored array, so a
    // same-cycle read of the destination sees the pre-write value.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we) begin
            regs_q[reg_add] <= wdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            co           <= 1'b0;
            z            <= 1'b0;
            busy_q       <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
        end else begin
            busy_q <= busy;
            if (flag_upd_w) begin
                co <= alu_co_w;
                z  <= (alu_res_w == '0);
            end
            // Capture uses opb_w, i.e. the contents before any write this edge.
            if (capture_w) begin
                result <= opb_w;
            end
            result_valid <= capture_w;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sub_datapath.sv
`default_nettype none
// ============================================================================
// Module      : tb_sub_datapath
// Description : Scoreboard bench for sub_datapath. The driver applies one
//               control word per cycle on the falling edge, advances a
//               behavioural model and queues the expected outputs; a monitor
//               compares the DUT outputs shortly after each rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sub_datapath;

    logic       clk;
    logic       rst;
    logic [7:0] data_in;
    logic [1:0] insel;
    logic [7:0] cu_const;
    logic [2:0] in_mux_add;
    logic [3:0] out_mux_add;
    logic [3:0] reg_add;
    logic       we;
    logic       busy;
    logic       co;
    logic       z;
    logic [7:0] result;
    logic       result_valid;

    sub_datapath #(.WIDTH(8), .NREG(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .data_in      (data_in),
        .insel        (insel),
        .cu_const     (cu_const),
        .in_mux_add   (in_mux_add),
        .out_mux_add  (out_mux_add),
        .reg_add      (reg_add),
        .we           (we),
        .busy         (busy),
        .co           (co),
        .z            (z),
        .result       (result),
        .result_valid (result_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       co;
        logic       z;
        logic       rv;
        logic [7:0] res;
    } exp_t;

    exp_t       eq[$];
    logic [7:0] rq[$];

    int compared   = 0;
    int mismatched = 0;

    // Behavioural model state
    int         m_regs [16];
    logic       m_co, m_z, m_busy_prev;
    logic [7:0] m_res;

    task automatic check(input string name, input int act, input int req);
        compared++;
        if (act != req) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // One clock cycle of stimulus plus the model's view of that edge.
    task automatic step(input logic r, input logic w, input logic [1:0] is,
                        input logic [3:0] ra, input logic [2:0] ia,
                        input logic [3:0] ob, input logic [7:0] d,
                        input logic [7:0] c, input logic b);
        int   a, bv, src;
        logic rv;
        exp_t e;
        @(negedge clk);
        rst = r; we = w; insel = is; reg_add = ra; in_mux_add = ia;
        out_mux_add = ob; data_in = d; cu_const = c; busy = b;
        rv = 1'b0;
        if (r) begin
            for (int i = 0; i < 16; i++) m_regs[i] = 0;
            m_co = 0; m_z = 0; m_busy_prev = 0; m_res = 0;
        end else begin
            a  = m_regs[ia];
            bv = m_regs[ob];
            if (m_busy_prev && !b) begin
                rv    = 1'b1;
                m_res = 8'(bv);
                rq.push_back(8'(bv));
            end
            if (w) begin
                case (is)
                    2'd0: src = d;
                    2'd1: src = c;
                    2'd2: begin
                        src  = (a - bv + 256) % 256;
                        m_co = (a >= bv);
                        m_z  = (src == 0);
                    end
                    default: src = a;
                endcase
                m_regs[ra] = src;
            end
            m_busy_prev = b;
        end
        e.co = m_co; e.z = m_z; e.rv = rv; e.res = m_res;
        eq.push_back(e);
    endtask

    // Capture helper: raise busy for a cycle, then drop it while selecting ob.
    task automatic read_reg(input logic [3:0] ob);
        step(0, 0, 0, 0, 0, ob, 0, 0, 1);
        step(0, 0, 0, 0, 0, ob, 0, 0, 0);
    endtask

    // Monitor: one expectation per clock; captured values on result_valid.
    initial begin
        exp_t       e;
        logic [7:0] r;
        forever begin
            @(posedge clk);
            #1;
            if (eq.size() != 0) begin
                e = eq.pop_front();
                check("co", int'(co), int'(e.co));
                check("z", int'(z), int'(e.z));
                check("result_valid", int'(result_valid), int'(e.rv));
                check("result_hold", int'(result), int'(e.res));
                if (result_valid) begin
                    if (rq.size() != 0) begin
                        r = rq.pop_front();
                        check("capture", int'(result), int'(r));
                    end else begin
                        compared++;
                        mismatched++;
                        $display("FAIL capture: unexpected pulse, result 0x%0h, expected no pulse", result);
                    end
                end else if (e.rv && rq.size() != 0) begin
                    void'(rq.pop_front());
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1; we = 0; insel = 0; reg_add = 0; in_mux_add = 0;
        out_mux_add = 0; data_in = 0; cu_const = 0; busy = 0;
        for (int i = 0; i < 16; i++) m_regs[i] = 0;
        m_co = 0; m_z = 0; m_busy_prev = 0; m_res = 0;

        // Reset with a write attempt pending
        step(1, 1, 1, 0, 0, 0, 0, 8'hAA, 0);
        step(1, 1, 1, 0, 0, 0, 0, 8'hAA, 0);
        read_reg(0);
        read_reg(4'hA);

        // Loads and subtract R1 = 0x0C - 0x05
        step(0, 1, 0, 1, 0, 0, 8'h0C, 0, 0);
        step(0, 1, 1, 2, 0, 0, 0, 8'h05, 0);
        step(0, 1, 2, 1, 1, 2, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        read_reg(1);

        // Equal (zero flag) and wrap-around (borrow)
        step(0, 1, 1, 3, 0, 0, 0, 8'h05, 0);
        step(0, 1, 2, 3, 3, 2, 0, 0, 0);
        read_reg(3);
        step(0, 1, 1, 4, 0, 0, 0, 8'h03, 0);
        step(0, 1, 2, 4, 4, 2, 0, 0, 0);
        read_reg(4);

        // Move leaves flags alone; top register reachable
        step(0, 1, 3, 9, 1, 0, 0, 0, 0);
        read_reg(9);
        step(0, 1, 1, 15, 0, 0, 0, 8'h5A, 0);
        read_reg(15);

        // Capture, quiet busy, capture concurrent with a write
        read_reg(1);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 0, 1);
        step(0, 1, 1, 1, 0, 1, 0, 8'h33, 0);
        read_reg(1);

        // Subtract plus busy fall in the same cycle
        step(0, 0, 0, 0, 0, 2, 0, 0, 1);
        step(0, 1, 2, 1, 1, 2, 0, 0, 0);
        read_reg(1);

        // Reset in the middle of a subtract with busy falling
        step(0, 0, 0, 0, 0, 2, 0, 0, 1);
        step(1, 1, 2, 1, 1, 2, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 0, 0);
        read_reg(1);
        step(0, 1, 0, 6, 0, 0, 8'h21, 0, 0);
        read_reg(6);

        // Randomised traffic
        for (int n = 0; n < 800; n++) begin
            step(($urandom_range(0, 99) == 0), 1'($urandom), 2'($urandom),
                 4'($urandom), 3'($urandom), 4'($urandom), 8'($urandom),
                 8'($urandom), 1'($urandom));
        end

        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #3;
        compared++;
        if (eq.size() != 0 || rq.size() != 0) begin
            mismatched++;
            $display("FAIL drain: %0d/%0d entries left, expected 0/0", eq.size(), rq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
